// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker: watches the count output of an up counter and reports
// wraps, threshold hits, stalls and illegal steps. All outputs are registered.
module count_wrap_tracker #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned WRAP_W    = 8,
  parameter int unsigned STALL_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count_in,
  input  logic              cnt_valid,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              clr,
  output logic              match_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              stalled,
  output logic              err_skip
);

  localparam int unsigned     SC_W      = $clog2(STALL_CYC) + 1;
  localparam logic [SC_W-1:0] STALL_LIM = SC_W'(STALL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    STALLED
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  prev_q, prev_nx;
  logic [SC_W-1:0]   stall_ctr, stall_nx, stall_inc;
  logic [CNT_W-1:0]  delta;
  logic              step_zero, step_ok, step_bad;

  logic              match_nx, wrap_nx, stalled_nx, err_nx;
  logic [WRAP_W-1:0] wrap_cnt_nx;

  assign delta     = count_in - prev_q;
  assign step_zero = (delta == '0);
  assign step_ok   = (delta == CNT_W'(1));
  assign step_bad  = !step_zero && !step_ok;
  assign stall_inc = stall_ctr + 1'b1;

  // State register with last sample and unchanged-step counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prev_q    <= '0;
      stall_ctr <= '0;
    end else begin
      state     <= state_nx;
      prev_q    <= prev_nx;
      stall_ctr <= stall_nx;
    end
  end

  // Next-state: only valid samples advance the tracker
  always_comb begin
    state_nx = state;
    prev_nx  = prev_q;
    stall_nx = stall_ctr;
    if (cnt_valid) begin
      prev_nx = count_in;
      case (state)
        IDLE: begin
          state_nx = TRACK;
          stall_nx = '0;
        end
        TRACK: begin
          if (step_zero) begin
            stall_nx = stall_inc;
            if (stall_inc == STALL_LIM) state_nx = STALLED;
          end else begin
            stall_nx = '0;
          end
        end
        STALLED: begin
          // counter stays parked at the limit while the count is frozen
          if (!step_zero) begin
            state_nx = TRACK;
            stall_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered status outputs
  always_comb begin
    match_nx    = 1'b0;
    wrap_nx     = 1'b0;
    stalled_nx  = stalled;
    err_nx      = err_skip;
    wrap_cnt_nx = wrap_cnt;
    if (cnt_valid && state != IDLE) begin
      if (step_ok) begin
        match_nx = (count_in == thresh);
        wrap_nx  = (prev_q == CNT_MAX) && (count_in == '0);
      end
      if (step_bad) err_nx = 1'b1;
      stalled_nx = (state_nx == STALLED);
      if (wrap_nx && wrap_cnt != '1) wrap_cnt_nx = wrap_cnt + 1'b1;
    end
    // clear wins over a same-edge wrap or error; the pulse itself still fires
    if (clr) begin
      wrap_cnt_nx = '0;
      err_nx      = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      wrap_cnt    <= '0;
      stalled     <= 1'b0;
      err_skip    <= 1'b0;
    end else begin
      match_pulse <= match_nx;
      wrap_pulse  <= wrap_nx;
      wrap_cnt    <= wrap_cnt_nx;
      stalled     <= stalled_nx;
      err_skip    <= err_nx;
    end
  end

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Testbench for count_wrap_tracker: directed scenarios plus random stimulus
// compared against a run-length based reference model.
module tb_count_wrap_tracker;

  localparam int unsigned STALL_CYC = 4;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       cnt_valid;
  logic [3:0] thresh;
  logic       clr;

  logic       match_pulse, wrap_pulse, stalled, err_skip;
  logic [7:0] wrap_cnt;
  logic       match_s, wrap_s, stalled_s, err_s;
  logic [1:0] wrap_cnt_s;

  int n_cmp;
  int n_bad;

  // reference model state
  bit         have_prev;
  logic [3:0] m_prev;
  int         m_run;
  bit         m_err, m_stalled, m_match, m_wrap;
  int         m_wraps, m_wraps_s;

  count_wrap_tracker #(.CNT_W(4), .WRAP_W(8), .STALL_CYC(STALL_CYC)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .cnt_valid(cnt_valid),
    .thresh(thresh), .clr(clr), .match_pulse(match_pulse),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .stalled(stalled),
    .err_skip(err_skip)
  );

  count_wrap_tracker #(.CNT_W(4), .WRAP_W(2), .STALL_CYC(STALL_CYC)) dut_sat (
    .clk(clk), .reset(reset), .count_in(count_in), .cnt_valid(cnt_valid),
    .thresh(thresh), .clr(clr), .match_pulse(match_s),
    .wrap_pulse(wrap_s), .wrap_cnt(wrap_cnt_s), .stalled(stalled_s),
    .err_skip(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    have_prev = 0; m_prev = '0; m_run = 0;
    m_err = 0; m_stalled = 0; m_match = 0; m_wrap = 0;
    m_wraps = 0; m_wraps_s = 0;
  endtask

  // one sampled edge in terms of the step between successive valid samples
  task automatic model_step(input logic [3:0] c, input bit v, input logic [3:0] th, input bit cl);
    logic [3:0] d;
    m_match = 0;
    m_wrap  = 0;
    if (v) begin
      if (!have_prev) begin
        have_prev = 1;
        m_run = 1;
      end else begin
        d = c - m_prev;
        if (d == 4'd1) begin
          m_run = 1;
          m_match = (c == th);
          if (m_prev == 4'd15 && c == 4'd0) begin
            m_wrap = 1;
            if (m_wraps < 255) m_wraps++;
            if (m_wraps_s < 3) m_wraps_s++;
          end
        end else if (d == 4'd0) begin
          m_run++;
        end else begin
          m_run = 1;
          m_err = 1;
        end
        m_stalled = (m_run >= STALL_CYC);
      end
      m_prev = c;
    end
    if (cl) begin
      m_wraps = 0;
      m_wraps_s = 0;
      m_err = 0;
    end
  endtask

  task automatic compare_all();
    check("match_pulse", match_pulse, m_match);
    check("wrap_pulse", wrap_pulse, m_wrap);
    check("wrap_cnt", wrap_cnt, m_wraps);
    check("stalled", stalled, m_stalled);
    check("err_skip", err_skip, m_err);
    check("sat_wrap_pulse", wrap_s, m_wrap);
    check("sat_wrap_cnt", wrap_cnt_s, m_wraps_s);
    check("sat_stalled", stalled_s, m_stalled);
    check("sat_err_skip", err_s, m_err);
    check("sat_match", match_s, m_match);
  endtask

  task automatic cycle(input logic [3:0] c, input bit v, input logic [3:0] th, input bit cl);
    count_in  = c;
    cnt_valid = v;
    thresh    = th;
    clr       = cl;
    @(posedge clk);
    model_step(c, v, th, cl);
    #1;
    compare_all();
  endtask

  // asynchronous reset away from the clock edge; outputs must clear at once
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, "_match"}, match_pulse, 0);
    check({tag, "_wrap"}, wrap_pulse, 0);
    check({tag, "_wrap_cnt"}, wrap_cnt, 0);
    check({tag, "_stalled"}, stalled, 0);
    check({tag, "_err"}, err_skip, 0);
    check({tag, "_sat_wrap_cnt"}, wrap_cnt_s, 0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] c, th;
    bit         v, cl;
    int         r;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    count_in = '0; cnt_valid = 1'b0; thresh = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;

    // free-run 0..15, 0..3 with thresh 5
    for (int i = 0; i < 20; i++) cycle(4'(i), 1'b1, 4'd5, 1'b0);
    check("freerun_wrap_cnt", wrap_cnt, 1);
    check("freerun_err", err_skip, 0);

    // five more full wraps: narrow counter saturates at 3
    c = 4'd3;
    for (int i = 0; i < 80; i++) begin
      c = c + 4'd1;
      cycle(c, 1'b1, 4'd5, 1'b0);
    end
    check("sat_final", wrap_cnt_s, 3);
    check("wide_final", wrap_cnt, 6);

    // stall: park on 7 for six samples, then step to 8
    cycle(4'd6, 1'b1, 4'd5, 1'b1);
    for (int i = 0; i < 6; i++) cycle(4'd7, 1'b1, 4'd5, 1'b0);
    check("stall_level", stalled, 1);
    cycle(4'd8, 1'b1, 4'd5, 1'b0);
    check("stall_exit", stalled, 0);
    check("stall_no_err", err_skip, 0);

    // skip 3,4,9 with thresh 9, then clear
    cycle(4'd3, 1'b1, 4'd9, 1'b0);
    cycle(4'd4, 1'b1, 4'd9, 1'b0);
    cycle(4'd9, 1'b1, 4'd9, 1'b0);
    check("skip_err", err_skip, 1);
    check("skip_no_match", match_pulse, 0);
    cycle(4'd10, 1'b1, 4'd9, 1'b1);
    check("clr_err", err_skip, 0);
    check("clr_wrap_cnt", wrap_cnt, 0);

    // reach wrap_cnt=2, then clear on the same edge as the next wrap
    c = 4'd10;
    for (int i = 0; i < 37; i++) begin
      c = c + 4'd1;
      cycle(c, 1'b1, 4'd9, 1'b0);
    end
    check("pre_simul_cnt", wrap_cnt, 2);
    cycle(4'd0, 1'b1, 4'd9, 1'b1);
    check("simul_pulse", wrap_pulse, 1);
    check("simul_cnt", wrap_cnt, 0);

    // reset mid-run at 6, restart at 11, freeze while counter advances
    for (int i = 1; i <= 6; i++) cycle(4'(i), 1'b1, 4'd9, 1'b0);
    async_reset("midrun_rst");
    cycle(4'd11, 1'b1, 4'd9, 1'b0);
    check("post_rst_err", err_skip, 0);
    for (int i = 12; i <= 14; i++) cycle(4'(i), 1'b0, 4'd9, 1'b0);
    cycle(4'd15, 1'b1, 4'd9, 1'b0);
    check("reenable_err", err_skip, 1);

    // random stimulus
    c = 4'd15;
    th = 4'd3;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 72) c = c + 4'd1;
      else if (r < 88) c = c;
      else c = 4'($urandom);
      v  = ($urandom_range(0, 9) != 0);
      cl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) th = 4'($urandom);
      if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
      cycle(c, v, th, cl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_wrap_tracker.md
Name: count_wrap_tracker

Overview:
- Downstream monitor for the 4-bit up counter; samples its count output every clock.
- Reports wrap-around events, threshold matches, stalls and illegal steps (any step other than +1 mod 2^CNT_W).
- Feeds status and debug logic.
- All outputs registered; purely synchronous except reset.

Parameters:
CNT_W, 4, width of monitored count
WRAP_W, 8, width of saturating wrap counter
STALL_CYC, 4, consecutive unchanged valid samples that declare a stall (min 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
count_in  input  CNT_W  count from up counter
cnt_valid  input  1  1 = counter running; samples ignored when 0
thresh  input  CNT_W  match value, sampled every cycle
clr  input  1  synchronous clear of wrap_cnt and err_skip
match_pulse  output  1  one-cycle pulse: count_in stepped onto thresh
wrap_pulse  output  1  one-cycle pulse: count_in stepped max→0
wrap_cnt  output  WRAP_W  number of wraps, saturates at all-ones
stalled  output  1  level: count unchanged ≥ STALL_CYC valid samples
err_skip  output  1  sticky: illegal step seen

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE; prev_q=0; stall_ctr=0.
  - All outputs 0.
- Sampling: each rising edge with cnt_valid=1 is a sample. Outputs update at that edge, so they reflect the step from the previous sample to the current count_in. Latency is 1 clock.
- cnt_valid=0: no state or counter change; pulses deasserted; stalled and err_skip hold.
- FSM states:
  - IDLE: first valid sample loads prev_q=count_in → TRACK. No pulses, no checks.
  - TRACK, per valid sample (d = count_in − prev_q mod 2^CNT_W):
    - d=1: legal step; stall_ctr=0.
      - wrap_pulse=1 if prev_q=max and count_in=0.
      - match_pulse=1 if count_in==thresh.
    - d=0: stall_ctr++. stall_ctr reaching STALL_CYC−1 → STALLED, stalled=1 at that edge.
    - Otherwise: err_skip=1 (sticky); stall_ctr=0; no pulses.
    - prev_q=count_in every valid sample.
  - STALLED: stalled=1. Next valid sample with d≠0 → TRACK and stalled=0 at that edge. That step is also evaluated as in TRACK: pulses if legal, err if illegal.
- wrap_cnt:
  - +1 per wrap_pulse.
  - Saturates at 2^WRAP_W−1; no wrap-around of wrap_cnt itself.
- clr:
  - Sets wrap_cnt=0 and err_skip=0 at the edge.
  - Has priority over a same-cycle wrap or error. wrap_cnt=0 and err_skip=0 even if an event occurs; wrap_pulse still asserts.
  - Does not affect FSM, prev_q or stalled.
- A counter reset to 0 mid-run from a value other than max is an illegal step → err_skip.
- Asserting reset mid-operation returns to IDLE; the first post-reset sample is not checked.
- thresh change takes effect on the next sample; a static count equal to thresh does not re-pulse.

Test Plan:
- Free-run: count 0..15,0..3 with cnt_valid=1, thresh=5, 10 ns clk → match_pulse exactly once per pass, at the edge sampling 5. wrap_pulse once, at the edge sampling 0 after 15. wrap_cnt=1. err_skip=0.
- Saturation: WRAP_W=2, run 5 full wraps → wrap_cnt reads 1,2,3,3,3; wrap_pulse still fires each wrap.
- Stall: hold count_in=7 for 6 valid cycles, STALL_CYC=4 → stalled rises at the 4th identical sample (3rd unchanged step). Then 8 applied → stalled=0 at that edge, no err_skip.
- Skip/error: sequence 3,4,9 → err_skip=1 after sampling 9; no match even if thresh=9. clr pulse → err_skip=0, wrap_cnt=0.
- Simultaneous: clr asserted on the same edge as the 15→0 step with wrap_cnt=2 → wrap_pulse=1, wrap_cnt=0 after the edge.
- Reset/valid: reset low mid-run at count 6 → all outputs 0 immediately (async, before next edge). Release with count_in=11 → no err on first sample. cnt_valid=0 for 3 cycles while count advances 12→15 → outputs frozen; the re-enabled sample flags err_skip.
